sudoku_hex_streamer: RTL and testbench

Downstream consumer of the one-hot-to-hex grid conversion: captures the 81-digit packed hex grid (4 bits per cell) on a start strobe and streams it out as ASCII characters, one per handshake, in row-major order with a row separator after each row. Feeds the text/debug output path (UART or trace FIFO) of the sudoku checker, so a solved or partial grid can be dumped without holding the converter inputs stable for the whole transfer.

---
 rtl/sudoku_hex_streamer.sv | 170 +++++++++++++++++
 tb/tb_sudoku_hex_streamer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_hex_streamer.sv
// Captures a packed 81-cell hex grid on start and streams it as ASCII over a
// valid/ready handshake, row-major, with an optional separator after each row.
module sudoku_hex_streamer #(
  parameter logic [7:0] BLANK_CHAR = 8'h2E,
  parameter logic [7:0] BAD_CHAR   = 8'h3F,
  parameter logic [7:0] ROW_SEP    = 8'h0A,
  parameter bit         EMIT_SEP   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [323:0] hex,
  output logic         busy,
  output logic         done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_char,
  output logic         out_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_FIN
  } state_t;

  state_t         state_q;
  logic [323:0]   grid_q;
  logic [3:0]     row_q, col_q;
  logic           sep_q;
  logic           busy_q, done_q, valid_q, last_q;
  logic [7:0]     char_q;

  logic [3:0]     row_d, col_d;
  logic           sep_d;
  logic [7:0]     char_d;
  logic           last_d;
  logic           hs;

  function automatic logic [7:0] map_cell(input logic [3:0] v);
    logic [7:0] c;
    if (v == 4'd0) begin
      c = BLANK_CHAR;
    end else if (v <= 4'd9) begin
      c = 8'h30 + {4'd0, v};
    end else begin
      c = BAD_CHAR;
    end
    return c;
  endfunction

  function automatic logic [3:0] cell_at(input logic [323:0] g,
                                         input logic [3:0]   r,
                                         input logic [3:0]   c);
    logic [6:0] idx;
    idx = {3'd0, r} * 7'd9 + {3'd0, c};
    return g[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic is_last(input logic [3:0] r, input logic [3:0] c,
                                   input logic s);
    logic l;
    if (EMIT_SEP) begin
      l = s && (r == 4'd8);
    end else begin
      l = !s && (r == 4'd8) && (c == 4'd8);
    end
    return l;
  endfunction

  assign hs = valid_q && out_ready;

  // Position and character that follow the one currently presented; the
  // final character never advances, so row/col stay within 0..8.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    row_d = row_q;
    col_d = col_q;
    sep_d = sep_q;
    if (!last_q) begin
      if (sep_q) begin
        sep_d = 1'b0;
        col_d = 4'd0;
        row_d = row_q + 4'd1;
      end else if (col_q != 4'd8) begin
        col_d = col_q + 4'd1;
      end else if (EMIT_SEP) begin
        sep_d = 1'b1;
      end else begin
        col_d = 4'd0;
        row_d = row_q + 4'd1;
      end
    end
    char_d = sep_d ? ROW_SEP : map_cell(cell_at(grid_q, row_d, col_d));
    last_d = is_last(row_d, col_d, sep_d);
  end

  // NOTE: the grid is pure datapath storage, so it is loaded on capture but not reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_IDLE && start) begin
      grid_q <= hex;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      sep_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      char_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_SEND;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            sep_q   <= 1'b0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            char_q  <= map_cell(hex[3:0]);
            last_q  <= 1'b0;
          end
        end
        S_SEND: begin
          if (hs) begin
            if (last_q) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              char_q  <= 8'h00;
              last_q  <= 1'b0;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              sep_q  <= sep_d;
              char_q <= char_d;
              last_q <= last_d;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_char  = char_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_sudoku_hex_streamer.sv
// Directed bench for sudoku_hex_streamer: one separator build and one
// digits-only build, checked against an independent grid-to-text model.
module tb_sudoku_hex_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [323:0] hex_a = '0, hex_b = '0;
  logic         rdy = 1'b0;

  logic busy_a, done_a, valid_a, last_a;
  logic busy_b, done_b, valid_b, last_b;
  logic [7:0] char_a, char_b;

  sudoku_hex_streamer #(.EMIT_SEP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hex(hex_a),
    .busy(busy_a), .done(done_a), .out_valid(valid_a), .out_ready(rdy),
    .out_char(char_a), .out_last(last_a)
  );

  sudoku_hex_streamer #(.EMIT_SEP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hex(hex_b),
    .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(rdy),
    .out_char(char_b), .out_last(last_b)
  );

  // sel picks which build the scenario tasks drive and observe
  logic       sel = 1'b0;
  logic       o_busy, o_done, o_valid, o_last;
  logic [7:0] o_char;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_last  = sel ? last_b  : last_a;
  assign o_char  = sel ? char_b  : char_a;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  function automatic logic [7:0] map_v(input logic [3:0] v);
    if (v == 4'd0) return 8'h2E;
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    return 8'h3F;
  endfunction

  function automatic logic [323:0] solved_grid();
    logic [323:0] g;
    g = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[(r*9+c)*4 +: 4] = 4'(((r*3 + r/3 + c) % 9) + 1);
    return g;
  endfunction

  function automatic void build_exp(input logic [323:0] g, input bit emit);
    exp_q.delete();
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) exp_q.push_back(map_v(g[(r*9+c)*4 +: 4]));
      if (emit) exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic set_start(input logic v, input logic [323:0] g);
    if (sel) begin start_b = v; hex_b = g; end
    else begin start_a = v; hex_a = g; end
  endtask

  task automatic launch(input logic [323:0] g);
    @(negedge clk);
    set_start(1'b1, g);
  endtask

  // Consume characters up to 'stop', checking order, out_last and stall hold.
  task automatic collect(input int n, input int stop, input bit rnd, input bit poke,
                         input logic [323:0] alt, output int busy_cyc, output int cyc);
    int idx;
    logic stalled;
    logic [7:0] pc;
    logic pl;
    idx = 0; cyc = 0; stalled = 1'b0; pc = 8'h00; pl = 1'b0; busy_cyc = 0;
    got_q.delete();
    while (idx < stop && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      set_start(poke && (cyc % 5 == 0), alt);
      if (o_busy) busy_cyc++;
      if (stalled) begin
        n_total++;
        if (o_valid !== 1'b1 || o_char !== pc || o_last !== pl)
          $display("FAIL stall_hold idx=%0d: got v=%b c=%h l=%b expected v=1 c=%h l=%b",
                   idx, o_valid, o_char, o_last, pc, pl);
        else n_pass++;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && rdy) begin
        n_total++;
        if (o_char !== exp_q[idx])
          $display("FAIL char idx=%0d: got %h expected %h", idx, o_char, exp_q[idx]);
        else n_pass++;
        n_total++;
        if (o_last !== (idx == n - 1))
          $display("FAIL last idx=%0d: got %b expected %b", idx, o_last, idx == n - 1);
        else n_pass++;
        got_q.push_back(o_char);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = o_valid;
        pc = o_char;
        pl = o_last;
      end
    end
    @(negedge clk);
    set_start(1'b0, alt);
    if (idx < stop) begin
      n_total++;
      $display("FAIL stream_timeout: got %0d chars expected %0d", idx, stop);
    end
  endtask

  // Entered one negedge after the final handshake edge (FIN cycle).
  task automatic finish_check(input bit fin_start, input logic [323:0] g_next);
    n_total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL fin_cycle: got done=%b busy=%b valid=%b expected 1 0 0",
               o_done, o_busy, o_valid);
    else n_pass++;
    if (fin_start) set_start(1'b1, g_next);
    @(negedge clk);
    n_total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL idle_after_fin: got done=%b busy=%b valid=%b expected 0 0 0",
               o_done, o_busy, o_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy_a, done_a, valid_a, last_a} !== 4'b0000)
      $display("FAIL reset_flags_a: got %b expected 0000", {busy_a, done_a, valid_a, last_a});
    else n_pass++;
    n_total++;
    if (char_a !== 8'h00) $display("FAIL reset_char_a: got %h expected 00", char_a);
    else n_pass++;
    n_total++;
    if ({busy_b, done_b, valid_b, last_b, char_b} !== 12'h000)
      $display("FAIL reset_b: got %h expected 000", {busy_b, done_b, valid_b, last_b, char_b});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_solved();
    int bc, cyc;
    logic [323:0] g;
    g = solved_grid();
    sel = 1'b0;
    build_exp(g, 1'b1);
    launch(g);
    collect(90, 90, 1'b0, 1'b0, g, bc, cyc);
    n_total++;
    if (bc !== 90) $display("FAIL solved_busy_cycles: got %0d expected 90", bc);
    else n_pass++;
    n_total++;
    if (cyc !== 90) $display("FAIL solved_throughput: got %0d expected 90", cyc);
    else n_pass++;
    n_total++;
    if (got_q.size() != 90 || got_q[0] !== 8'h31 || got_q[9] !== 8'h0A || got_q[10] !== 8'h34)
      $display("FAIL solved_row_text: got size=%0d", got_q.size());
    else n_pass++;
    finish_check(1'b0, g);
  endtask

  task automatic test_bad_char();
    int bc, cyc, nbad;
    logic [323:0] g;
    g = '0;
    g[40*4 +: 4] = 4'hF;
    sel = 1'b0;
    build_exp(g, 1'b1);
    launch(g);
    collect(90, 90, 1'b0, 1'b0, g, bc, cyc);
    nbad = 0;
    foreach (got_q[i]) if (got_q[i] == 8'h3F) nbad++;
    n_total++;
    if (got_q.size() != 90 || got_q[44] !== 8'h3F || nbad != 1)
      $display("FAIL bad_char_44: got %h count=%0d expected 3f count=1",
               got_q.size() > 44 ? got_q[44] : 8'h00, nbad);
    else n_pass++;
    finish_check(1'b0, g);
  endtask

  task automatic test_backpressure();
    int bc, cyc;
    logic [323:0] g;
    g = solved_grid();
    sel = 1'b0;
    build_exp(g, 1'b1);
    launch(g);
    collect(90, 90, 1'b1, 1'b0, g, bc, cyc);
    n_total++;
    if (got_q.size() != 90) $display("FAIL bp_count: got %0d expected 90", got_q.size());
    else n_pass++;
    finish_check(1'b0, g);
  endtask

  task automatic test_start_ignored();
    int bc, cyc;
    logic [323:0] g1, g2;
    g1 = solved_grid();
    g2 = '0;
    g2[3:0] = 4'd7;
    sel = 1'b0;
    build_exp(g1, 1'b1);
    launch(g1);
    collect(90, 90, 1'b0, 1'b1, g2, bc, cyc);
    finish_check(1'b1, g2);
    build_exp(g2, 1'b1);
    collect(90, 90, 1'b0, 1'b0, g2, bc, cyc);
    n_total++;
    if (got_q.size() != 90 || got_q[0] !== 8'h37)
      $display("FAIL restart_after_fin: got size=%0d", got_q.size());
    else n_pass++;
    finish_check(1'b0, g2);
  endtask

  task automatic test_abort();
    int bc, cyc;
    logic seen_done;
    logic [323:0] g;
    g = solved_grid();
    sel = 1'b0;
    build_exp(g, 1'b1);
    launch(g);
    collect(90, 37, 1'b0, 1'b0, g, bc, cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({o_valid, o_busy, o_done, o_last, o_char} !== 12'h000)
      $display("FAIL abort_outputs: got %h expected 000", {o_valid, o_busy, o_done, o_last, o_char});
    else n_pass++;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_done || o_valid) seen_done = 1'b1;
    end
    n_total++;
    if (seen_done !== 1'b0) $display("FAIL abort_quiet: got activity expected none");
    else n_pass++;
    launch(g);
    collect(90, 90, 1'b0, 1'b0, g, bc, cyc);
    finish_check(1'b0, g);
  endtask

  task automatic test_no_sep();
    int bc, cyc, nsep;
    logic [323:0] g;
    g = solved_grid();
    sel = 1'b1;
    build_exp(g, 1'b0);
    launch(g);
    collect(81, 81, 1'b0, 1'b0, g, bc, cyc);
    nsep = 0;
    foreach (got_q[i]) if (got_q[i] == 8'h0A) nsep++;
    n_total++;
    if (bc !== 81 || nsep != 0)
      $display("FAIL nosep_stream: got busy=%0d seps=%0d expected 81 0", bc, nsep);
    else n_pass++;
    finish_check(1'b0, g);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_solved();
    test_bad_char();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_no_sep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
